booth_mac_seq: RTL and testbench

Parametrised sequential radix-2 Booth multiply-accumulate unit. It is the next generation of the team's 8-bit Booth multiplier and adds the following:
- generic operand width
- runtime signed/unsigned mode
- full 2*WIDTH product output
- start/ready handshake
- registered accumulator with sticky overflow

It feeds the MAC datapath, one product per WIDTH+1 compute cycles.

---
 rtl/booth_mac_seq_if.sv | 27 ++
 rtl/booth_mac_seq.sv | 153 +++++++++++++++
 tb/tb_booth_mac_seq.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/booth_mac_seq_if.sv
// Handshake and data bundle for booth_mac_seq: request side (master) and MAC unit (slave).
interface booth_mac_seq_if #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+8
);
   logic                   start;
   logic                   ready;
   logic [WIDTH-1:0]       x;
   logic [WIDTH-1:0]       y;
   logic                   mode_signed;
   logic                   acc_en;
   logic                   acc_clr;
   logic                   valid;
   logic [2*WIDTH-1:0]     product;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   acc_ovf;

   modport master (
      output start, x, y, mode_signed, acc_en, acc_clr,
      input  ready, valid, product, acc, acc_ovf
   );

   modport slave (
      input  start, x, y, mode_signed, acc_en, acc_clr,
      output ready, valid, product, acc, acc_ovf
   );
endinterface

// File: rtl/booth_mac_seq.sv
// Sequential radix-2 Booth multiply-accumulate: one product every WIDTH+1 steps,
// optional accumulate into a wrapping register with a sticky overflow flag.
module booth_mac_seq #(
   parameter int WIDTH     = 8,
   parameter int ACC_WIDTH = 2*WIDTH+8
) (
   input logic          clk,
   input logic          rst,
   booth_mac_seq_if.slave bus
);
   localparam int LW = WIDTH + 1;
   localparam int UW = WIDTH + 2;
   localparam int PW = 2*WIDTH;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [UW-1:0]        upper_q, upper_d;
   logic [LW-1:0]        lower_q, lower_d;
   logic                 booth_q, booth_d;
   logic [UW-1:0]        mcand_q, mcand_d;
   logic                 signed_q, signed_d;
   logic                 en_q, en_d;
   logic                 clr_q, clr_d;
   logic [PW-1:0]        product_q, product_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic                 valid_q, valid_d;

   logic [UW-1:0]        step_sum;
   logic [UW-1:0]        upper_n;
   logic [LW-1:0]        lower_n;
   logic [PW-1:0]        prod_n;
   logic [ACC_WIDTH-1:0] prod_ext;
   logic [ACC_WIDTH:0]   acc_sum;
   logic                 add_ovf;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         upper_q   <= '0;
         lower_q   <= '0;
         booth_q   <= 1'b0;
         mcand_q   <= '0;
         signed_q  <= 1'b0;
         en_q      <= 1'b0;
         clr_q     <= 1'b0;
         product_q <= '0;
         acc_q     <= '0;
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         upper_q   <= upper_d;
         lower_q   <= lower_d;
         booth_q   <= booth_d;
         mcand_q   <= mcand_d;
         signed_q  <= signed_d;
         en_q      <= en_d;
         clr_q     <= clr_d;
         product_q <= product_d;
         acc_q     <= acc_d;
         ovf_q     <= ovf_d;
         valid_q   <= valid_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      upper_d   = upper_q;
      lower_d   = lower_q;
      booth_d   = booth_q;
      mcand_d   = mcand_q;
      signed_d  = signed_q;
      en_d      = en_q;
      clr_d     = clr_q;
      product_d = product_q;
      acc_d     = acc_q;
      ovf_d     = ovf_q;
      valid_d   = 1'b0;

      step_sum = upper_q;
      case ({lower_q[0], booth_q})
         2'b10:   step_sum = upper_q - mcand_q;
         2'b01:   step_sum = upper_q + mcand_q;
         default: step_sum = upper_q;
      endcase
      // Arithmetic right shift of the combined {upper, lower} partial product.
      upper_n = {step_sum[UW-1], step_sum[UW-1:1]};
      lower_n = {step_sum[0], lower_q[LW-1:1]};
      prod_n  = {upper_n[WIDTH-2:0], lower_n};

      if (signed_q) prod_ext = ACC_WIDTH'(signed'(prod_n));
      else          prod_ext = ACC_WIDTH'(prod_n);
      acc_sum = {1'b0, acc_q} + {1'b0, prod_ext};
      if (signed_q)
         add_ovf = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                   (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
      else
         add_ovf = acc_sum[ACC_WIDTH];

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               signed_d = bus.mode_signed;
               en_d     = bus.acc_en;
               clr_d    = bus.acc_clr;
               if (bus.mode_signed) begin
                  mcand_d = UW'(signed'(bus.x));
                  lower_d = LW'(signed'(bus.y));
               end else begin
                  mcand_d = UW'(bus.x);
                  lower_d = LW'(bus.y);
               end
               upper_d = '0;
               booth_d = 1'b0;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            upper_d = upper_n;
            lower_d = lower_n;
            booth_d = lower_q[0];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH)) begin
               state_d   = IDLE;
               valid_d   = 1'b1;
               product_d = prod_n;
               if (clr_q) begin
                  acc_d = prod_ext;
                  ovf_d = 1'b0;
               end else if (en_q) begin
                  acc_d = acc_sum[ACC_WIDTH-1:0];
                  if (add_ovf) ovf_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.ready   = (state_q == IDLE);
   assign bus.valid   = valid_q;
   assign bus.product = product_q;
   assign bus.acc     = acc_q;
   assign bus.acc_ovf = ovf_q;
endmodule

// File: tb/tb_booth_mac_seq.sv
// Directed bench for booth_mac_seq: a 24-bit-accumulator and a 16-bit-accumulator
// instance share the same stimulus; expected values are hand-computed constants.
module tb_booth_mac_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   booth_mac_seq_if #(.WIDTH(8)) b8 ();
   booth_mac_seq_if #(.WIDTH(8), .ACC_WIDTH(16)) b16 ();

   booth_mac_seq #(.WIDTH(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   booth_mac_seq #(.WIDTH(8), .ACC_WIDTH(16)) u_dut16 (
      .clk (clk),
      .rst (rst),
      .bus (b16)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [7:0] xv, input logic [7:0] yv,
                        input logic ms, input logic en, input logic clr);
      b8.start = s;        b16.start = s;
      b8.x = xv;           b16.x = xv;
      b8.y = yv;           b16.y = yv;
      b8.mode_signed = ms; b16.mode_signed = ms;
      b8.acc_en = en;      b16.acc_en = en;
      b8.acc_clr = clr;    b16.acc_clr = clr;
   endtask

   task automatic set_start(input logic s);
      b8.start = s;
      b16.start = s;
   endtask

   task automatic set_x(input logic [7:0] xv);
      b8.x = xv;
      b16.x = xv;
   endtask

   // Issue one operation and return at #1 after the edge that raises valid.
   task automatic op(input string tag, input logic [7:0] xv, input logic [7:0] yv,
                     input logic ms, input logic en, input logic clr,
                     output int lat, output int rdy_hi);
      @(negedge clk);
      drive(1'b1, xv, yv, ms, en, clr);
      @(posedge clk);
      #1 set_start(1'b0);
      lat = 0;
      rdy_hi = 0;
      while (!b8.valid && lat < 20) begin
         if (b8.ready) rdy_hi++;
         @(posedge clk);
         #1 lat++;
      end
      chk({tag, "_latency"}, lat, 9);
   endtask

   initial begin
      int lat, rdy_hi, nval, stray;
      drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ready", b8.ready, 1);
      chk("rst_valid", b8.valid, 0);
      chk("rst_product", b8.product, 0);
      chk("rst_acc", b8.acc, 0);
      chk("rst_ovf", b8.acc_ovf, 0);

      // Most-negative operands
      op("m128sq", 8'h80, 8'h80, 1'b1, 1'b0, 1'b0, lat, rdy_hi);
      chk("m128sq_ready_low", rdy_hi, 0);
      chk("m128sq_product", b8.product, 16'h4000);
      chk("m128sq_ready_at_valid", b8.ready, 1);
      @(posedge clk);
      #1 chk("m128sq_valid_one_cycle", b8.valid, 0);
      op("m128x127", 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, lat, rdy_hi);
      chk("m128x127_product", b8.product, 16'hC080);

      // Same bits, both modes
      op("ff_uns", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, lat, rdy_hi);
      chk("ff_uns_product", b8.product, 16'hFE01);
      op("ff_sgn", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, lat, rdy_hi);
      chk("ff_sgn_product", b8.product, 16'h0001);

      // Signed accumulate
      op("acc1", 8'd3, 8'd4, 1'b1, 1'b0, 1'b1, lat, rdy_hi);
      chk("acc1_acc", b8.acc, 24'd12);
      chk("acc1_ovf", b8.acc_ovf, 0);
      op("acc2", 8'hFB, 8'd7, 1'b1, 1'b1, 1'b0, lat, rdy_hi);
      chk("acc2_product", b8.product, 16'hFFDD);
      chk("acc2_acc", b8.acc, 24'hFFFFE9);
      chk("acc2_ovf", b8.acc_ovf, 0);
      op("acc3", 8'd2, 8'd2, 1'b1, 1'b0, 1'b0, lat, rdy_hi);
      chk("acc3_product", b8.product, 16'd4);
      chk("acc3_acc", b8.acc, 24'hFFFFE9);
      chk("acc3_ovf", b8.acc_ovf, 0);

      // start held high: accepts at edges 1, 11, 21; valids at 10, 20, 30
      @(negedge clk);
      drive(1'b1, 8'd3, 8'd5, 1'b0, 1'b0, 1'b0);
      nval = 0;
      stray = 0;
      for (int i = 1; i <= 30; i++) begin
         @(posedge clk);
         #1;
         if (i == 4) set_x(8'd9);
         if (i == 14) set_x(8'd7);
         if (b8.valid) begin
            nval++;
            if (i == 10)      chk("hold_p1", b8.product, 16'd15);
            else if (i == 20) chk("hold_p2", b8.product, 16'd45);
            else if (i == 30) chk("hold_p3", b8.product, 16'd35);
            else stray++;
         end
      end
      set_start(1'b0);
      chk("hold_nvalid", nval, 3);
      chk("hold_stray", stray, 0);
      chk("hold_acc_kept", b8.acc, 24'hFFFFE9);

      // start during RUN is dropped
      @(negedge clk);
      drive(1'b1, 8'd2, 8'd3, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1 set_start(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      set_start(1'b1);
      set_x(8'd10);
      @(posedge clk);
      #1 set_start(1'b0);
      nval = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (b8.valid) begin
            nval++;
            chk("runstart_product", b8.product, 16'd6);
         end
      end
      chk("runstart_nvalid", nval, 1);

      // Reset in the 4th RUN cycle
      @(negedge clk);
      drive(1'b1, 8'd5, 8'd5, 1'b1, 1'b0, 1'b1);
      @(posedge clk);
      #1 set_start(1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mrst_ready", b8.ready, 1);
      chk("mrst_valid", b8.valid, 0);
      chk("mrst_product", b8.product, 0);
      chk("mrst_acc", b8.acc, 0);
      chk("mrst_ovf", b8.acc_ovf, 0);
      nval = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1 if (b8.valid) nval++;
      end
      chk("mrst_no_valid", nval, 0);
      op("post_rst", 8'd6, 8'hF9, 1'b1, 1'b0, 1'b0, lat, rdy_hi);
      chk("post_rst_product", b8.product, 16'hFFD6);

      // 16-bit accumulator: signed overflow, stickiness, clear
      op("o1", 8'd127, 8'd127, 1'b1, 1'b0, 1'b1, lat, rdy_hi);
      chk("o1_acc16", b16.acc, 16'h3F01);
      chk("o1_ovf16", b16.acc_ovf, 0);
      op("o2", 8'd127, 8'd127, 1'b1, 1'b1, 1'b0, lat, rdy_hi);
      chk("o2_acc16", b16.acc, 16'h7E02);
      chk("o2_ovf16", b16.acc_ovf, 0);
      op("o3", 8'd127, 8'd127, 1'b1, 1'b1, 1'b0, lat, rdy_hi);
      chk("o3_acc16", b16.acc, 16'hBD03);
      chk("o3_ovf16", b16.acc_ovf, 1);
      chk("o3_acc24", b8.acc, 24'h00BD03);
      chk("o3_ovf24", b8.acc_ovf, 0);
      op("o4", 8'd1, 8'd1, 1'b1, 1'b1, 1'b0, lat, rdy_hi);
      chk("o4_acc16", b16.acc, 16'hBD04);
      chk("o4_ovf16_sticky", b16.acc_ovf, 1);
      op("o5", 8'd2, 8'd3, 1'b1, 1'b0, 1'b1, lat, rdy_hi);
      chk("o5_acc16", b16.acc, 16'd6);
      chk("o5_ovf16_cleared", b16.acc_ovf, 0);

      // Unsigned carry-out overflow
      op("u1", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, lat, rdy_hi);
      chk("u1_acc16", b16.acc, 16'hFE01);
      chk("u1_ovf16", b16.acc_ovf, 0);
      op("u2", 8'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, lat, rdy_hi);
      chk("u2_acc16", b16.acc, 16'hFC02);
      chk("u2_ovf16", b16.acc_ovf, 1);
      chk("u2_acc24", b8.acc, 24'h01FC02);
      chk("u2_ovf24", b8.acc_ovf, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
